// File: rtl/packet_pkg.sv
// Shared types for the packet receiver: FSM state encoding, result codes and
// the byte parity helper.
package packet_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_PARITY = 3'd2,
    RX_DRAIN  = 3'd3,
    RX_DONE   = 3'd4
  } rx_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_LENGTH = 2'b10;
  localparam logic [1:0] ERR_TRUNC  = 2'b11;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/packet_rx_buffer.sv
// Payload store: MAX_LEN x 8 RAM, one synchronous write port and one registered
// read port; reads beyond MAX_LEN return zero, same-address read sees old data.
module packet_rx_buffer #(
  parameter int MAX_LEN = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Wr_en,
  input  logic [7:0] Wr_addr,
  input  logic [7:0] Wr_data,
  input  logic [7:0] Rd_addr,
  output logic [7:0] Rd_data
);

  localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] LIMIT = 9'(MAX_LEN);

  logic [7:0] mem [2**AW];

  always_ff @(posedge Clk) begin
    if (Wr_en && ({1'b0, Wr_addr} < LIMIT))
      mem[Wr_addr[AW-1:0]] <= Wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      Rd_data <= 8'h00;
    else if ({1'b0, Rd_addr} < LIMIT)
      Rd_data <= mem[Rd_addr[AW-1:0]];
    else
      Rd_data <= 8'h00;
  end

endmodule

// File: rtl/packet_receiver.sv
// Receive-side framer: length byte, payload, parity check, held result until Ack.
// Define PACKET_RX_STATS_EN to add saturating Good_cnt / Err_cnt counters.
//
// state     | meaning
// RX_IDLE   | waiting for a rising In_flag carrying the length byte
// RX_DATA   | storing payload bytes until count reaches Pkt_len
// RX_PARITY | comparing the trailing byte against the running parity
// RX_DRAIN  | waiting for In_flag to drop (overlong frame or length error)
// RX_DONE   | result presented on Pkt_done/Pkt_err until Ack
module packet_receiver
  import packet_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In,
  input  logic       In_flag,
  input  logic [7:0] Rd_addr,
  output logic [7:0] Rd_data,
  output logic [7:0] Pkt_len,
  output logic       Pkt_done,
  output logic [1:0] Pkt_err,
  input  logic       Ack,
  output logic       Busy
`ifdef PACKET_RX_STATS_EN
  ,
  output logic [15:0] Good_cnt,
  output logic [15:0] Err_cnt
`endif
);

  localparam logic [8:0] LEN_LIMIT = 9'(MAX_LEN);

  rx_state_t  state;
  logic       flag_q;
  logic       parity;
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic       wr_en;

  assign count_nxt = count + 8'd1;
  assign wr_en     = (state == RX_DATA) && In_flag;
  assign Busy      = (state != RX_IDLE);

  // flag_q resets high so a frame already in flight is never taken as a new start
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= RX_IDLE;
      flag_q   <= 1'b1;
      parity   <= 1'b0;
      count    <= 8'd0;
      Pkt_len  <= 8'd0;
      Pkt_done <= 1'b0;
      Pkt_err  <= ERR_NONE;
    end else begin
      flag_q <= In_flag;
      case (state)
        RX_IDLE: begin
          if (In_flag && !flag_q) begin
            Pkt_len <= In;
            parity  <= byte_parity(In);
            count   <= 8'd0;
            Pkt_err <= ERR_NONE;
            if ({1'b0, In} > LEN_LIMIT) begin
              Pkt_err <= ERR_LENGTH;
              state   <= RX_DRAIN;
            end else if (In == 8'd0) begin
              state <= RX_PARITY;
            end else begin
              state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (In_flag) begin
            parity <= parity ^ byte_parity(In);
            count  <= count_nxt;
            if (count_nxt == Pkt_len)
              state <= RX_PARITY;
          end else begin
            Pkt_err  <= ERR_TRUNC;
            Pkt_done <= 1'b1;
            state    <= RX_DONE;
          end
        end
        RX_PARITY: begin
          if (In_flag) begin
            if (In != {7'b0, parity})
              Pkt_err <= ERR_PARITY;
            state <= RX_DRAIN;
          end else begin
            Pkt_err  <= ERR_TRUNC;
            Pkt_done <= 1'b1;
            state    <= RX_DONE;
          end
        end
        RX_DRAIN: begin
          if (!In_flag) begin
            Pkt_done <= 1'b1;
            state    <= RX_DONE;
          end
        end
        RX_DONE: begin
          // an Ack while a frame is still flowing drains it rather than joining mid-packet
          if (Ack) begin
            Pkt_done <= 1'b0;
            state    <= In_flag ? RX_DRAIN : RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  packet_rx_buffer #(.MAX_LEN(MAX_LEN)) u_buffer (
    .Clk     (Clk),
    .Rst     (Rst),
    .Wr_en   (wr_en),
    .Wr_addr (count),
    .Wr_data (In),
    .Rd_addr (Rd_addr),
    .Rd_data (Rd_data)
  );

`ifdef PACKET_RX_STATS_EN
  logic done_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      done_d   <= 1'b0;
      Good_cnt <= 16'd0;
      Err_cnt  <= 16'd0;
    end else begin
      done_d <= Pkt_done;
      if (Pkt_done && !done_d) begin
        if (Pkt_err == ERR_NONE) begin
          if (Good_cnt != 16'hFFFF) Good_cnt <= Good_cnt + 16'd1;
        end else begin
          if (Err_cnt != 16'hFFFF) Err_cnt <= Err_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver with hand-computed expectations.
module tb_packet_receiver;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] In = 8'h00;
  logic       In_flag = 1'b0;
  logic [7:0] Rd_addr = 8'h00;
  logic [7:0] Rd_data;
  logic [7:0] Pkt_len;
  logic       Pkt_done;
  logic [1:0] Pkt_err;
  logic       Ack = 1'b0;
  logic       Busy;
`ifdef PACKET_RX_STATS_EN
  logic [15:0] Good_cnt;
  logic [15:0] Err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  packet_receiver #(.MAX_LEN(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .In       (In),
    .In_flag  (In_flag),
    .Rd_addr  (Rd_addr),
    .Rd_data  (Rd_data),
    .Pkt_len  (Pkt_len),
    .Pkt_done (Pkt_done),
    .Pkt_err  (Pkt_err),
    .Ack      (Ack),
    .Busy     (Busy)
`ifdef PACKET_RX_STATS_EN
    ,
    .Good_cnt (Good_cnt),
    .Err_cnt  (Err_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // drive on the falling edge, observe 1 time unit after the rising edge
  task automatic tick(input logic f, input logic [7:0] d);
    @(negedge Clk);
    In_flag = f;
    In      = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic ack_release();
    Ack = 1'b1;
    tick(1'b0, 8'h00);
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Pkt_done); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", Pkt_err); end
    checks++; if (Pkt_len !== 8'h00) begin errors++; $display("FAIL reset_len: got %h expected 00", Pkt_len); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h expected 00", Rd_data); end
    Rst = 1'b0;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_good();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    tick(1'b1, 8'h03);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b expected 1", Busy); end
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h03);
    tick(1'b1, 8'h00);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL good_done_early: got %b expected 0", Pkt_done); end
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL good_done: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL good_err: got %b expected 00", Pkt_err); end
    checks++; if (Pkt_len !== 8'h03) begin errors++; $display("FAIL good_len: got %h expected 03", Pkt_len); end
    for (int i = 0; i < 3; i++) begin
      Rd_addr = 8'(i);
      tick(1'b0, 8'h00);
      checks++; if (Rd_data !== exp_d[i]) begin errors++; $display("FAIL good_rd%0d: got %h expected %h", i, Rd_data, exp_d[i]); end
    end
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL good_held: got %b expected 1", Pkt_done); end
    ack_release();
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL good_ack_done: got %b expected 0", Pkt_done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL good_ack_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_parity();
    logic [7:0] bad [2];
    bad[0] = 8'h01; bad[1] = 8'h02;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 8'h03);
      tick(1'b1, 8'h01);
      tick(1'b1, 8'h02);
      tick(1'b1, 8'h03);
      tick(1'b1, bad[k]);
      tick(1'b0, 8'h00);
      checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL parity_done%0d: got %b expected 1", k, Pkt_done); end
      checks++; if (Pkt_err !== 2'b01) begin errors++; $display("FAIL parity_err%0d: got %b expected 01", k, Pkt_err); end
      ack_release();
    end
  endtask

  task automatic test_length();
    tick(1'b1, 8'h40);
    for (int i = 0; i < 65; i++) tick(1'b1, 8'hAA);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL len_drain_done: got %b expected 0", Pkt_done); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL len_drain_busy: got %b expected 1", Busy); end
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL len_done: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b10) begin errors++; $display("FAIL len_err: got %b expected 10", Pkt_err); end
    checks++; if (Pkt_len !== 8'h40) begin errors++; $display("FAIL len_len: got %h expected 40", Pkt_len); end
    Rd_addr = 8'd0;
    tick(1'b0, 8'h00);
    checks++; if (Rd_data !== 8'h01) begin errors++; $display("FAIL len_rd0: got %h expected 01", Rd_data); end
    Rd_addr = 8'd32;
    tick(1'b0, 8'h00);
    checks++; if (Rd_data !== 8'h00) begin errors++; $display("FAIL len_rd32: got %h expected 00", Rd_data); end
    Rd_addr = 8'd255;
    tick(1'b0, 8'h00);
    checks++; if (Rd_data !== 8'h00) begin errors++; $display("FAIL len_rd255: got %h expected 00", Rd_data); end
    ack_release();
  endtask

  task automatic test_trunc();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h03;
    tick(1'b1, 8'h03);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL trunc_done: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b11) begin errors++; $display("FAIL trunc_err: got %b expected 11", Pkt_err); end
    for (int i = 0; i < 3; i++) begin
      Rd_addr = 8'(i);
      tick(1'b0, 8'h00);
      checks++; if (Rd_data !== exp_d[i]) begin errors++; $display("FAIL trunc_rd%0d: got %h expected %h", i, Rd_data, exp_d[i]); end
    end
    // Ack while a new frame is already flowing: drain it, keep the old result
    Ack = 1'b1;
    tick(1'b1, 8'h02);
    Ack = 1'b0;
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL ackflag_done: got %b expected 0", Pkt_done); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ackflag_busy: got %b expected 1", Busy); end
    tick(1'b1, 8'h44);
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL ackflag_redone: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b11) begin errors++; $display("FAIL ackflag_err: got %b expected 11", Pkt_err); end
    checks++; if (Pkt_len !== 8'h03) begin errors++; $display("FAIL ackflag_len: got %h expected 03", Pkt_len); end
    ack_release();
  endtask

  task automatic test_zero_len();
    tick(1'b1, 8'h00);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", Busy); end
    tick(1'b1, 8'h00);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b expected 0", Pkt_done); end
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL zero_err: got %b expected 00", Pkt_err); end
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h06);
    tick(1'b1, 8'h07);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_len !== 8'h00) begin errors++; $display("FAIL lost_len: got %h expected 00", Pkt_len); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL lost_err: got %b expected 00", Pkt_err); end
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL lost_done: got %b expected 1", Pkt_done); end
    ack_release();
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL zero_ack_done: got %b expected 0", Pkt_done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL zero_ack_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'h03);
    tick(1'b1, 8'h55);
    Rst = 1'b1;
    tick(1'b1, 8'h66);
    Rst = 1'b0;
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b expected 0", Pkt_done); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL rmid_err: got %b expected 00", Pkt_err); end
    checks++; if (Pkt_len !== 8'h00) begin errors++; $display("FAIL rmid_len: got %h expected 00", Pkt_len); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", Busy); end
    checks++; if (Rd_data !== 8'h00) begin errors++; $display("FAIL rmid_rd: got %h expected 00", Rd_data); end
    tick(1'b1, 8'h77);
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b0) begin errors++; $display("FAIL rmid_tail_done: got %b expected 0", Pkt_done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_tail_busy: got %b expected 0", Busy); end
    // clean packet: L=2, 81, 7E; parity = ^02 ^ ^81 ^ ^7E = 1
    Rd_addr = 8'd0;
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h81);
    checks++; if (Rd_data !== 8'h55) begin errors++; $display("FAIL rmid_rdw: got %h expected 55", Rd_data); end
    tick(1'b1, 8'h7E);
    tick(1'b1, 8'h01);
    tick(1'b0, 8'h00);
    checks++; if (Pkt_done !== 1'b1) begin errors++; $display("FAIL clean_done: got %b expected 1", Pkt_done); end
    checks++; if (Pkt_err !== 2'b00) begin errors++; $display("FAIL clean_err: got %b expected 00", Pkt_err); end
    checks++; if (Pkt_len !== 8'h02) begin errors++; $display("FAIL clean_len: got %h expected 02", Pkt_len); end
    Rd_addr = 8'd0;
    tick(1'b0, 8'h00);
    checks++; if (Rd_data !== 8'h81) begin errors++; $display("FAIL clean_rd0: got %h expected 81", Rd_data); end
    Rd_addr = 8'd1;
    tick(1'b0, 8'h00);
    checks++; if (Rd_data !== 8'h7E) begin errors++; $display("FAIL clean_rd1: got %h expected 7E", Rd_data); end
    ack_release();
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_length();
    test_trunc();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
